// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W=4*NIBBLES operands one nibble per clock
// using a 4-bit carry-lookahead nibble adder and a carry register.
// Optional subtraction (a - b) is enabled by defining NIBBLE_SERIAL_SUB_EN,
// which adds the 'sub' input port.

// Two-level carry-lookahead nibble adder.
module nibble_cla (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = x ^ y;
    assign g = x & y;

    // Each carry is written in flattened sum-of-products form so no carry
    // depends on another carry.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s    = p ^ c;
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic                   sub,
`endif
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry;
    logic [IW-1:0] idx;
    logic [3:0]    nib_s;
    logic          nib_c;
    logic          sub_i;

`ifdef NIBBLE_SERIAL_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    nibble_cla u_cla (
        .x  (a_q[4*idx +: 4]),
        .y  (b_q[4*idx +: 4]),
        .ci (carry),
        .s  (nib_s),
        .co (nib_c)
    );

    // Control FSM plus datapath registers; all outputs are registered.
    // For subtraction, b is stored inverted and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= sub_i ? ~b : b;
                        carry    <= sub_i;
                        idx      <= '0;
                        sum      <= '0;
                        state    <= ADD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ADD: begin
                    sum[4*idx +: 4] <= nib_s;
                    carry           <= nib_c;
                    idx             <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout      <= nib_c;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): vector table
// through a scoreboard queue, plus hand-written backpressure, ignored-input
// and reset-abort sequences.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] s;
        logic        c;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Offer one operand pair; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                        input logic [15:0] es, input logic ec);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        a = va; b = vb; sub = vs; in_valid = 1'b1;
        @(posedge clk);
        e.s = es; e.c = ec;
        sb.push_back(e);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Wait for out_valid, check latency, pop the scoreboard and compare.
    task automatic wait_result(input string tag);
        int lat = 0;
        exp_t e;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, 4);
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_result"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, {16'd0, sum}, {16'd0, e.s});
            chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
        end
    endtask

    initial begin
        logic [15:0] hold_s;
        int seen;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;

        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
        vecs.push_back('{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0});
        vecs.push_back('{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0});
`ifdef NIBBLE_SERIAL_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven vectors
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c);
            chk("busy_in_add", {31'd0, busy}, 32'd1);
            chk("in_ready_in_add", {31'd0, in_ready}, 32'd0);
            wait_result($sformatf("vec%0d", i));
            @(negedge clk);
            chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
            chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_sum_kept", {16'd0, sum}, {16'd0, vecs[i].s});
        end

        // Backpressure: result held stable for 10 cycles
        out_ready = 1'b0;
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        while (!out_valid && checks < 100000) begin
            @(negedge clk);
            if (sb.size() == 0) break;
            if (busy == 1'b0 && !out_valid) break;
        end
        chk("bp_out_valid_reached", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold", {14'd0, out_valid, cout, sum}, {14'd0, 1'b1, 1'b1, 16'h0000});
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("bp_sum", {16'd0, sum}, {16'd0, e.s});
            chk("bp_cout", {31'd0, cout}, {31'd0, e.c});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // in_valid with new operands during ADD is ignored
        send(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);
        a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
        wait_result("ignore");
        in_valid = 1'b0;
        @(negedge clk);
        chk("ignore_idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("ignore_not_accepted", {30'd0, in_ready, busy}, {30'd0, 1'b1, 1'b0});

        // Reset during the second ADD cycle aborts the operation
        send(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_sum", {16'd0, sum}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);

        // Normal operation afterwards
        send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        wait_result("post_abort");
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
